// File: rtl/div64x32.sv
// div64x32: sequential restoring divider, 2W-bit dividend / W-bit divisor -> W-bit quotient and remainder
//   clk, reset (async, active-high), start: handshake inputs
//   dividend[2W-1:0], divisor[W-1:0]: operands, captured only when start is accepted in IDLE
//   busy: high during CHECK and RUN
//   quotient, remainder: results, held from the fall of busy until the next accepted start
//   div_by_zero, overflow: error flags for the last accepted operation
module div64x32 #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           busy,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);
    typedef enum logic [1:0] {IDLE, CHECK, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [W-1:0] r_q, q_q, d_q, quot_q, rem_q;
    logic [CW-1:0] cnt_q;
    logic dz_q, ov_q;
    logic [W:0] r_sh;
    logic ge;
    logic [W-1:0] r_nx, q_nx;
    logic last, err;
    // R < divisor is guaranteed in RUN, so the shifted remainder needs only one extra bit
    assign r_sh = {r_q, q_q[W-1]};
    assign ge   = r_sh >= {1'b0, d_q};
    assign r_nx = ge ? W'(r_sh - {1'b0, d_q}) : r_sh[W-1:0];
    assign q_nx = {q_q[W-2:0], ge};
    assign last = cnt_q == LAST;
    // r_q holds the dividend's upper half during CHECK
    assign err  = d_q == '0 || r_q >= d_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? CHECK : IDLE;
            CHECK:   state_d = err ? DONE : RUN;
            RUN:     state_d = last ? DONE : RUN;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        busy = state_q == CHECK || state_q == RUN;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q    <= '0;
            q_q    <= '0;
            d_q    <= '0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dz_q   <= 1'b0;
            ov_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    r_q  <= dividend[2*W-1:W];
                    q_q  <= dividend[W-1:0];
                    d_q  <= divisor;
                    dz_q <= 1'b0;
                    ov_q <= 1'b0;
                end
                CHECK: begin
                    cnt_q <= '0;
                    if (d_q == '0) begin
                        dz_q   <= 1'b1;
                        quot_q <= '1;
                        rem_q  <= q_q;
                    end else if (err) begin
                        ov_q   <= 1'b1;
                        quot_q <= '1;
                        rem_q  <= '0;
                    end
                end
                RUN: begin
                    r_q   <= r_nx;
                    q_q   <= q_nx;
                    cnt_q <= cnt_q + 1'b1;
                    // results are published only once the final bit is known
                    if (last) begin
                        quot_q <= q_nx;
                        rem_q  <= r_nx;
                    end
                end
                default: ;
            endcase
        end
    end
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dz_q;
    assign overflow    = ov_q;
endmodule

// File: tb/tb_div64x32.sv
// tb_div64x32: self-checking bench for div64x32 against an arithmetic reference model
module tb_div64x32;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [63:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic [31:0] quotient, remainder;
    logic        div_by_zero, overflow;
    int checks = 0;
    int errors = 0;

    div64x32 #(.W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: divide-by-zero and quotient-overflow rules, otherwise plain integer division
    task automatic model(input logic [63:0] n, input logic [31:0] d,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic dz, output logic ov, output int cyc);
        logic [63:0] qq, rr;
        dz = d == 0;
        ov = !dz && n[63:32] >= d;
        cyc = (dz || ov) ? 1 : 33;
        if (dz) begin
            q = '1; r = n[31:0];
        end else if (ov) begin
            q = '1; r = '0;
        end else begin
            qq = n / {32'd0, d};
            rr = n % {32'd0, d};
            q = qq[31:0]; r = rr[31:0];
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns at a negedge with the DUT in IDLE
    task automatic op(input string tag, input logic [63:0] n, input logic [31:0] d, input bit hold);
        logic [31:0] eq, er;
        logic edz, eov;
        int ecyc, cyc;
        model(n, d, eq, er, edz, eov, ecyc);
        start = 1'b1; dividend = n; divisor = d;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        dividend = {$urandom, $urandom};
        divisor = $urandom;
        cyc = 0;
        @(negedge clk);
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        chk({tag, " busy_cycles"}, 64'(cyc), 64'(ecyc));
        chk({tag, " quotient"}, 64'(quotient), 64'(eq));
        chk({tag, " remainder"}, 64'(remainder), 64'(er));
        chk({tag, " div_by_zero"}, 64'(div_by_zero), 64'(edz));
        chk({tag, " overflow"}, 64'(overflow), 64'(eov));
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk({tag, " no_restart"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [31:0] a, b, r;
        repeat (3) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset quotient", 64'(quotient), 64'd0);
        chk("reset remainder", 64'(remainder), 64'd0);
        chk("reset flags", 64'({div_by_zero, overflow}), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        op("t1", 64'd100, 32'd7, 1'b0);
        chk("t1 literal q", 64'(quotient), 64'd14);
        op("t2", 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 1'b0);
        chk("t2 literal q", 64'(quotient), 64'hFFFF_FFFF);
        op("t3", 64'h0000_0000_1234_5678, 32'd0, 1'b0);
        chk("t3 literal r", 64'(remainder), 64'h1234_5678);
        op("t4", 64'h0000_0001_0000_0000, 32'd1, 1'b0);
        op("t4b", 64'd9, 32'd3, 1'b0);
        repeat (5) @(negedge clk);
        chk("idle hold quotient", 64'(quotient), 64'd3);
        // abort in the middle of RUN
        start = 1'b1; dividend = 64'd100; divisor = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (11) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort quotient", 64'(quotient), 64'd0);
        chk("abort remainder", 64'(remainder), 64'd0);
        chk("abort flags", 64'({div_by_zero, overflow}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        op("t5 hold", 64'd1000, 32'd33, 1'b1);
        op("t6", 64'(32'h1234_5678) * 64'(32'h9ABC_DEF0), 32'h1234_5678, 1'b0);
        chk("t6 literal q", 64'(quotient), 64'h9ABC_DEF0);
        for (int i = 0; i < 1000; i++) begin
            do a = $urandom; while (a == 0);
            b = $urandom;
            r = $urandom % a;
            op("rand", 64'(a) * 64'(b) + 64'(r), a, 1'b0);
            chk("rand roundtrip q", 64'(quotient), 64'(b));
            chk("rand roundtrip r", 64'(remainder), 64'(r));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
